gamma_pulse_scheduler: RTL and testbench
========================================

// Module: gamma_pulse_scheduler
// PURPOSE
// Serialises race-logic edges from N_REQ requesters onto one shared unary pulse lane. Each winner
// gets one PULSE_WIDTH-cycle pulse tagged with its index. Tags, grant state and drop reports are
// framed by an internal gamma-cycle counter. Sits between column edge outputs and the shared
// pulse-domain link.
// PARAMETERS
// N_REQ             4   number of requesters (>=2)
// GAMMA_CYCLE_WIDTH 16  aclk cycles per gamma cycle (> PULSE_WIDTH+1)
// PULSE_WIDTH       8   aclk cycles per emitted pulse (>=1)
// PORTS
// aclk          in   1                      unit clock
// rst           in   1                      reset
// edge_in       in   N_REQ                  per-requester edge level; stays high once fired within gamma
// pulse_out     out  1                      shared pulse lane
// pulse_id      out  $clog2(N_REQ)          index owning current pulse; 0 when pulse_out low
// gamma_start   out  1                      high while gamma_cnt==0
// drop_mask     out  N_REQ                  requesters unserved in previous gamma
// BEHAVIOUR
// - Reset rst, synchronous, active-high; clock aclk. All outputs registered.
// - Reset values: pulse_out=0, pulse_id=0, drop_mask=0, gamma_cnt=0 (so gamma_start=1),
//   pending=0, served=0, rr_ptr=0, state=IDLE.
// - gamma_cnt: width $clog2(GAMMA_CYCLE_WIDTH), counts 0..GAMMA_CYCLE_WIDTH-1, then wraps to 0.
// - Request capture: req = (pending | edge_in) & ~served; pending |= edge_in each cycle.
// - FSM states IDLE, PULSE, GAP:
//   IDLE->PULSE when req!=0 and gamma_cnt <= GAMMA_CYCLE_WIDTH-1-PULSE_WIDTH;
//     at that edge: grant registered, served[g] set, pulse_out=1 and pulse_id=g from next cycle.
//   PULSE: pulse_out held exactly PULSE_WIDTH cycles; pulse counter width $clog2(PULSE_WIDTH)+1.
//   PULSE->GAP after the PULSE_WIDTH-th cycle. GAP is 1 cycle with pulse_out=0, then GAP->IDLE.
//   The mandatory gap keeps adjacent pulses distinguishable downstream.
// - Latency: edge_in first high at edge with gamma_cnt=c in IDLE (eligible) -> pulse_out high for
//   gamma_cnt c+1..c+PULSE_WIDTH. Pulses never straddle a gamma boundary.
// - Arbitration: round-robin; search starts at rr_ptr. After grant g, rr_ptr=(g+1) mod N_REQ.
//   After reset, index 0 has highest priority.
// - Gamma wrap (edge where gamma_cnt==GAMMA_CYCLE_WIDTH-1):
//   drop_mask <= req (edge_in included that cycle); pending<=0; served<=0; rr_ptr is kept.
//   edge_in sampled at this edge belongs to the ending gamma; new-gamma capture starts at gamma_cnt=0.
// - Late requests: requests ineligible because of the gamma_cnt bound stay pending until the wrap,
//   then appear in drop_mask. Each requester gets at most one pulse per gamma.
// - Simultaneous requests at one edge: exactly one grant; the rest wait for IDLE.
// - Reset mid-pulse: pulse_out drops the next cycle; no partial pulse is resumed.
// STRUCTURE
// - Shared package tnn_pkg: typedef enum logic [1:0] {SCH_IDLE, SCH_PULSE, SCH_GAP} sched_state_t;
//   and a function for gamma_cnt width.
// - Sub-module rr_arbiter #(N):
//   inputs: req[N], ptr
//   outputs: gnt_valid, gnt_idx
//   purely combinational rotate-priority encoder
// - Top level holds gamma counter, pending/served masks, FSM, pulse counter and output registers.
// TESTING  (defaults N_REQ=4, GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8)
// - Reset: assert rst 3 cycles mid-run -> next cycle pulse_out=0, drop_mask=0, gamma_start=1.
// - Single request: edge_in[2] high at gamma_cnt=3 -> pulse_out=1, pulse_id=2 for gamma_cnt 4..11;
//   drop_mask=0 after wrap.
// - Contention: edge_in=4'b1010 at gamma_cnt=0 -> id1 pulse at cnt 1..8, gap at cnt 9; id3 ineligible
//   (cnt 10>7) -> drop_mask=4'b1000 after wrap.
// - Round-robin: edge_in=4'b0011 at cnt 0 in consecutive gammas -> first winners 0, then 1, then 0.
// - Late edge: edge_in[0] high at gamma_cnt=8 -> no pulse; drop_mask=4'b0001 for the next gamma.
// - Boundary: edge_in[1] high at gamma_cnt=7 -> pulse at cnt 8..15; next gamma_start has pulse_out=0.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared types and helpers for the temporal-neural-network pulse-domain blocks.
package tnn_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_PULSE = 2'd1,
    SCH_GAP   = 2'd2
  } sched_state_t;

  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gamma_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter
  import tnn_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = cnt_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_idx
);

  logic [ID_W-1:0] idx_s;
  int              pos_s;

  // Walk offsets from farthest to nearest so the nearest requester is the last writer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx_s     = '0;
    pos_s     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pos_s     = int'(ptr) + i;
      pos_s     = (pos_s >= N) ? (pos_s - N) : pos_s;
      idx_s     = ID_W'(pos_s);
      gnt_valid = gnt_valid | req[idx_s];
      gnt_idx   = req[idx_s] ? idx_s : gnt_idx;
    end
  end

endmodule

// File: rtl/gamma_pulse_scheduler.sv
// Serialises per-requester race-logic edges onto one shared unary pulse lane,
// one PULSE_WIDTH pulse per winner per gamma cycle, with a one-cycle gap between pulses.
module gamma_pulse_scheduler
  import tnn_pkg::*;
#(
  parameter int N_REQ             = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              edge_in,
  output logic                          pulse_out,
  output logic [cnt_width(N_REQ)-1:0]   pulse_id,
  output logic                          gamma_start,
  output logic [N_REQ-1:0]              drop_mask
);

  localparam int ID_W = cnt_width(N_REQ);
  localparam int GW   = cnt_width(GAMMA_CYCLE_WIDTH);
  localparam int PW   = $clog2(PULSE_WIDTH) + 1;

  sched_state_t     state_q, state_d;
  logic [GW-1:0]    gamma_cnt_q, gamma_cnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [N_REQ-1:0] drop_q, drop_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             pulse_q, pulse_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             gstart_q, gstart_d;

  logic [N_REQ-1:0] req_s;
  logic [N_REQ-1:0] grant_mask_s;
  logic             gnt_valid_s;
  logic [ID_W-1:0]  gnt_idx_s;
  logic             gamma_last_s;
  logic             eligible_s;
  logic             grant_s;
  logic             pulse_done_s;

  assign req_s        = (pending_q | edge_in) & ~served_q;
  assign gamma_last_s = (gamma_cnt_q == GW'(GAMMA_CYCLE_WIDTH - 1));
  // A grant must leave room for the whole pulse before the gamma boundary.
  assign eligible_s   = (gamma_cnt_q <= GW'(GAMMA_CYCLE_WIDTH - 1 - PULSE_WIDTH));
  assign grant_s      = (state_q == SCH_IDLE) && gnt_valid_s && eligible_s;
  assign pulse_done_s = (pcnt_q == PW'(PULSE_WIDTH));
  assign grant_mask_s = grant_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_s) : '0;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_s),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= SCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCH_IDLE:  state_d = grant_s ? SCH_PULSE : SCH_IDLE;
      SCH_PULSE: state_d = pulse_done_s ? SCH_GAP : SCH_PULSE;
      SCH_GAP:   state_d = SCH_IDLE;
      default:   state_d = SCH_IDLE;
    endcase
  end

  always_comb begin
    pulse_d = 1'b0;
    id_d    = '0;
    pcnt_d  = '0;
    case (state_q)
      SCH_IDLE: begin
        if (grant_s) begin
          pulse_d = 1'b1;
          id_d    = gnt_idx_s;
          pcnt_d  = PW'(1);
        end else begin
          pulse_d = 1'b0;
        end
      end
      SCH_PULSE: begin
        if (pulse_done_s) begin
          pulse_d = 1'b0;
        end else begin
          pulse_d = 1'b1;
          id_d    = id_q;
          pcnt_d  = pcnt_q + PW'(1);
        end
      end
      SCH_GAP: pulse_d = 1'b0;
      default: pulse_d = 1'b0;
    endcase
  end

  // Gamma framing: the wrap edge closes the gamma and reports whatever was still unserved.
  always_comb begin
    gamma_cnt_d = gamma_last_s ? '0 : (gamma_cnt_q + GW'(1));
    gstart_d    = (gamma_cnt_d == '0);
    rr_ptr_d    = rr_ptr_q;
    if (gamma_last_s) begin
      pending_d = '0;
      served_d  = '0;
      drop_d    = req_s;
    end else begin
      pending_d = pending_q | edge_in;
      served_d  = served_q | grant_mask_s;
      drop_d    = drop_q;
    end
    if (grant_s) begin
      rr_ptr_d = (gnt_idx_s == ID_W'(N_REQ - 1)) ? '0 : (gnt_idx_s + ID_W'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      gamma_cnt_q <= '0;
      pcnt_q      <= '0;
      pending_q   <= '0;
      served_q    <= '0;
      drop_q      <= '0;
      rr_ptr_q    <= '0;
      pulse_q     <= 1'b0;
      id_q        <= '0;
      gstart_q    <= 1'b1;
    end else begin
      gamma_cnt_q <= gamma_cnt_d;
      pcnt_q      <= pcnt_d;
      pending_q   <= pending_d;
      served_q    <= served_d;
      drop_q      <= drop_d;
      rr_ptr_q    <= rr_ptr_d;
      pulse_q     <= pulse_d;
      id_q        <= id_d;
      gstart_q    <= gstart_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign pulse_id    = id_q;
  assign gamma_start = gstart_q;
  assign drop_mask   = drop_q;

endmodule

// File: tb/tb_gamma_pulse_scheduler.sv
// Directed bench for gamma_pulse_scheduler at N_REQ=4, GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8.
module tb_gamma_pulse_scheduler;

  logic       aclk = 1'b0;
  logic       rst;
  logic [3:0] edge_in;
  logic       pulse_out;
  logic [1:0] pulse_id;
  logic       gamma_start;
  logic [3:0] drop_mask;

  int total = 0;
  int bad   = 0;

  gamma_pulse_scheduler #(
    .N_REQ             (4),
    .GAMMA_CYCLE_WIDTH (16),
    .PULSE_WIDTH       (8)
  ) dut (
    .aclk        (aclk),
    .rst         (rst),
    .edge_in     (edge_in),
    .pulse_out   (pulse_out),
    .pulse_id    (pulse_id),
    .gamma_start (gamma_start),
    .drop_mask   (drop_mask)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Runs one full gamma starting in the gamma_cnt==0 cycle; exp_start<0 means no pulse.
  task automatic run_gamma(input string name, input logic [3:0] ev, input int at,
                           input int exp_id, input int exp_start, input logic [3:0] exp_drop);
    logic exp_p;
    for (int c = 0; c < 16; c++) begin
      exp_p = (exp_start >= 0) && (c >= exp_start) && (c < exp_start + 8);
      check({name, "_pulse"}, 32'(pulse_out), 32'(exp_p));
      check({name, "_id"}, 32'(pulse_id), exp_p ? exp_id : 0);
      check({name, "_gstart"}, 32'(gamma_start), 32'(c == 0));
      if (c == at) edge_in = ev;
      step();
    end
    edge_in = 4'b0000;
    check({name, "_drop"}, 32'(drop_mask), 32'(exp_drop));
    check({name, "_next_pulse"}, 32'(pulse_out), 32'(0));
  endtask

  initial begin
    rst     = 1'b1;
    edge_in = 4'b0000;
    repeat (3) step();
    rst = 1'b0;

    check("rst_pulse", 32'(pulse_out), 32'(0));
    check("rst_id", 32'(pulse_id), 32'(0));
    check("rst_drop", 32'(drop_mask), 32'(0));
    check("rst_gstart", 32'(gamma_start), 32'(1));

    run_gamma("contend", 4'b1010, 0, 1, 1, 4'b1000);
    run_gamma("single", 4'b0100, 3, 2, 4, 4'b0000);
    run_gamma("late", 4'b0001, 8, 0, -1, 4'b0001);

    edge_in = 4'b0010;
    repeat (3) step();
    check("pre_rst_pulse", 32'(pulse_out), 32'(1));
    check("pre_rst_id", 32'(pulse_id), 32'(1));
    check("pre_rst_drop", 32'(drop_mask), 32'(4'b0001));
    rst = 1'b1;
    step();
    check("mid_rst_pulse", 32'(pulse_out), 32'(0));
    check("mid_rst_id", 32'(pulse_id), 32'(0));
    check("mid_rst_drop", 32'(drop_mask), 32'(0));
    check("mid_rst_gstart", 32'(gamma_start), 32'(1));
    step();
    step();
    rst     = 1'b0;
    edge_in = 4'b0000;

    run_gamma("rr1", 4'b0011, 0, 0, 1, 4'b0010);
    run_gamma("rr2", 4'b0011, 0, 1, 1, 4'b0001);
    run_gamma("rr3", 4'b0011, 0, 0, 1, 4'b0010);
    run_gamma("bound", 4'b0010, 7, 1, 8, 4'b0000);
    check("bound_gstart", 32'(gamma_start), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
